// File: rtl/pwr_subckt_eval_pipe.sv
// Purpose: per-channel f = (d | (a^c)) & (a | (b & (a^c))) with per-channel saturating output-toggle counters.
// Latency: LATENCY cycles from accept to out_valid when out_ready stays high; throughput 1 sample/cycle.
// Backpressure: elastic valid/ready stages; in_ready is the combinational ready chain back from out_ready.
module pwr_subckt_eval_pipe #(
    parameter int CHANNELS = 4,
    parameter int LATENCY  = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*CHANNELS-1:0]     in_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS-1:0]       out_f,
    input  logic                      cnt_clear,
    output logic [CNT_W*CHANNELS-1:0] toggle_cnt,
    output logic [CHANNELS-1:0]       cnt_sat
);

    logic [CHANNELS-1:0]                  f_in;
    logic [LATENCY-1:0]                   take;
    logic [LATENCY-1:0]                   vld_q, vld_d;
    logic [LATENCY-1:0][CHANNELS-1:0]     dat_q, dat_d;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  prev_q, prev_d;
    logic                                 out_xfer;

    // Evaluate the sub-circuit function for every channel straight from the input sample
    always_comb begin
        f_in = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            f_in[i] = (in_vec[4*i+3] | (in_vec[4*i] ^ in_vec[4*i+2]))
                    & (in_vec[4*i] | (in_vec[4*i+1] & (in_vec[4*i] ^ in_vec[4*i+2])));
        end
    end

    // Ready chain: a stage can take new contents if it is empty or the stage after it can take
    always_comb begin
        logic t;
        take = '0;
        t    = ~vld_q[LATENCY-1] | out_ready;
        take[LATENCY-1] = t;
        for (int k = LATENCY - 2; k >= 0; k--) begin
            t       = ~vld_q[k] | t;
            take[k] = t;
        end
    end

    assign in_ready  = take[0] & ~rst;
    assign out_valid = vld_q[LATENCY-1];
    assign out_f     = dat_q[LATENCY-1];
    assign out_xfer  = out_valid & out_ready;

    // Next-state of the pipeline: bubbles move as invalid, data only loads behind a valid source
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (take[0]) begin
            vld_d[0] = in_valid;
            if (in_valid) begin
                dat_d[0] = f_in;
            end
        end
        for (int k = 1; k < LATENCY; k++) begin
            if (take[k]) begin
                vld_d[k] = vld_q[k-1];
                if (vld_q[k-1]) begin
                    dat_d[k] = dat_q[k-1];
                end
            end
        end
    end

    // Toggle counters: clear wins over a same-cycle transfer; counting stops at all-ones
    always_comb begin
        cnt_d  = cnt_q;
        prev_d = prev_q;
        if (cnt_clear) begin
            cnt_d  = '0;
            prev_d = '0;
        end else if (out_xfer) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if ((out_f[i] != prev_q[i]) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            prev_d = out_f;
        end
    end

    // Saturation flags come straight from the counter values
    always_comb begin
        cnt_sat = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_sat[i] = &cnt_q[i];
        end
    end

    assign toggle_cnt = cnt_q;

    // State registers; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            dat_q  <= '0;
            cnt_q  <= '0;
            prev_q <= '0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: tb/tb_pwr_subckt_eval_pipe.sv
// Purpose: self-checking bench for pwr_subckt_eval_pipe across three parameter sets.
// Latency: checks accept-to-output delay, bubbles, stalls, counters and reset behaviour.
// Backpressure: random and directed out_ready stalls against a queue-based reference.
module tb_pwr_subckt_eval_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Main instance: 4 channels, latency 2, 16-bit counters
    logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_cnt_clear = 0;
    logic [15:0] a_in_vec = '0;
    logic [3:0]  a_out_f, a_cnt_sat;
    logic [63:0] a_toggle_cnt;

    // Single-channel instance with 3-bit counters (truth table, saturation)
    logic        s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 1, s_cnt_clear = 0;
    logic [3:0]  s_in_vec = '0;
    logic [0:0]  s_out_f, s_cnt_sat;
    logic [2:0]  s_toggle_cnt;

    // Single-channel instance with latency 3 (bubbles)
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_cnt_clear = 0;
    logic [3:0]  b_in_vec = '0;
    logic [0:0]  b_out_f, b_cnt_sat;
    logic [15:0] b_toggle_cnt;

    pwr_subckt_eval_pipe #(.CHANNELS(4), .LATENCY(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_vec(a_in_vec),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_f(a_out_f),
        .cnt_clear(a_cnt_clear), .toggle_cnt(a_toggle_cnt), .cnt_sat(a_cnt_sat));

    pwr_subckt_eval_pipe #(.CHANNELS(1), .LATENCY(2), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_vec(s_in_vec),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_f(s_out_f),
        .cnt_clear(s_cnt_clear), .toggle_cnt(s_toggle_cnt), .cnt_sat(s_cnt_sat));

    pwr_subckt_eval_pipe #(.CHANNELS(1), .LATENCY(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_vec(b_in_vec),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_f(b_out_f),
        .cnt_clear(b_cnt_clear), .toggle_cnt(b_toggle_cnt), .cnt_sat(b_cnt_sat));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference function from the boolean definition, all four channels
    function automatic logic [3:0] fref4(input logic [15:0] v);
        logic [3:0] r;
        logic a, b, c, d, x;
        for (int i = 0; i < 4; i++) begin
            a = v[4*i]; b = v[4*i+1]; c = v[4*i+2]; d = v[4*i+3];
            x = a ^ c;
            r[i] = (d | x) & (a | (b & x));
        end
        return r;
    endfunction

    // Reference model for dut_a: in-flight queue plus per-channel counters
    logic [3:0]  q[$];
    int unsigned mcnt[4];
    logic [3:0]  mprev = '0;
    logic        last_stall = 0;
    logic [3:0]  last_f = '0;
    int          n_xfer = 0;

    always @(negedge clk) begin
        logic [63:0] expc;
        logic [3:0]  exps;
        logic [3:0]  e;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 4; i++) mcnt[i] = 0;
            mprev = '0;
            last_stall = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                expc[16*i +: 16] = mcnt[i][15:0];
                exps[i] = (mcnt[i] == 65535);
            end
            chk("mon_cnt", a_toggle_cnt, expc);
            chk("mon_sat", 64'(a_cnt_sat), 64'(exps));
            chk("mon_in_ready", 64'(a_in_ready), 64'((q.size() < 2) || a_out_ready));
            if (last_stall) begin
                chk("mon_stall_valid", 64'(a_out_valid), 64'd1);
                chk("mon_stall_data", 64'(a_out_f), 64'(last_f));
            end
            if (a_out_valid && a_out_ready) begin
                n_xfer++;
                if (q.size() == 0) begin
                    chk("mon_spurious_out", 64'(q.size()), 64'd1);
                end else begin
                    e = q.pop_front();
                    chk("mon_order", 64'(a_out_f), 64'(e));
                    if (!a_cnt_clear) begin
                        for (int i = 0; i < 4; i++)
                            if (e[i] != mprev[i] && mcnt[i] < 65535) mcnt[i]++;
                        mprev = e;
                    end
                end
            end
            if (a_cnt_clear) begin
                for (int i = 0; i < 4; i++) mcnt[i] = 0;
                mprev = '0;
            end
            if (a_in_valid && a_in_ready) q.push_back(fref4(a_in_vec));
            last_stall = a_out_valid && !a_out_ready;
            last_f = a_out_f;
        end
    end

    // Hold a sample on dut_a until accepted, with a bounded wait
    task automatic send_a(input logic [15:0] v);
        logic acc;
        int   k;
        a_in_valid = 1;
        a_in_vec   = v;
        acc = 0;
        k = 0;
        while (!acc && k < 100) begin
            @(negedge clk);
            acc = a_in_ready;
            cyc();
            k++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
        a_in_valid = 0;
    endtask

    typedef struct { logic [3:0] abcd; logic f; } tt_t;
    typedef struct { logic in_v; logic exp_ov; } bub_t;

    initial begin
        tt_t         tt[16];
        bub_t        bub[8];
        logic [15:0] tt_bits;
        int          x0;
        tt_bits = 16'b1110_1010_0100_1010;
        for (int i = 0; i < 16; i++) begin
            tt[i].abcd = 4'(i);
            tt[i].f    = tt_bits[i];
        end
        for (int k = 0; k < 8; k++) begin
            bub[k].in_v   = (k == 0) || (k == 2);
            bub[k].exp_ov = (k == 3) || (k == 5);
        end

        // Reset state
        #2;
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_f", 64'(a_out_f), 64'd0);
        chk("rst_toggle_cnt", a_toggle_cnt, 64'd0);
        chk("rst_cnt_sat", 64'(a_cnt_sat), 64'd0);
        cyc();
        rst = 0;
        #1;
        chk("rel_in_ready", 64'(a_in_ready), 64'd1);
        cyc();

        // Truth table, one code per cycle, result two cycles later
        for (int i = 0; i < 18; i++) begin
            s_in_valid = (i < 16);
            s_in_vec   = (i < 16) ? tt[i].abcd : 4'd0;
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("tt_valid_%0d", i - 2), 64'(s_out_valid), 64'd1);
                chk($sformatf("tt_f_%0d", i - 2), 64'(s_out_f), 64'(tt[i-2].f));
            end
            cyc();
        end
        s_in_valid = 0;
        cyc();

        // Bubbles through a 3-deep pipeline
        for (int k = 0; k < 8; k++) begin
            b_in_valid = bub[k].in_v;
            b_in_vec   = 4'h1;
            @(negedge clk);
            chk($sformatf("bubble_ov_%0d", k), 64'(b_out_valid), 64'(bub[k].exp_ov));
            cyc();
        end
        b_in_valid = 0;

        // Backpressure: six samples against a stalled output
        a_out_ready = 0;
        x0 = n_xfer;
        fork
            begin
                for (int i = 0; i < 6; i++) send_a(16'($urandom));
            end
            begin
                repeat (4) cyc();
                chk("bp_ready_low", 64'(a_in_ready), 64'd0);
                chk("bp_held", 64'(q.size()), 64'd2);
                repeat (3) cyc();
                a_out_ready = 1;
            end
        join
        repeat (5) cyc();
        chk("bp_drained", 64'(q.size()), 64'd0);
        chk("bp_xfers", 64'(n_xfer - x0), 64'd6);

        // Toggle count on channel 0: results 1,0,0,1,1
        a_cnt_clear = 1;
        cyc();
        a_cnt_clear = 0;
        foreach (tt_bits[i]) if (i < 5) begin
            a_in_valid = 1;
            a_in_vec   = (i == 0 || i == 3 || i == 4) ? 16'h0001 : 16'h0000;
            cyc();
        end
        a_in_valid = 0;
        repeat (3) cyc();
        chk("tog_cnt3", a_toggle_cnt, 64'd3);
        // Clear concurrent with a transfer of 0
        a_in_valid = 1;
        a_in_vec   = 16'h0000;
        cyc();
        a_in_valid = 0;
        cyc();
        a_cnt_clear = 1;
        @(negedge clk);
        chk("clr_xfer_valid", 64'(a_out_valid), 64'd1);
        chk("clr_xfer_f", 64'(a_out_f), 64'd0);
        cyc();
        a_cnt_clear = 0;
        @(negedge clk);
        chk("clr_cnt0", a_toggle_cnt, 64'd0);
        cyc();
        a_in_valid = 1;
        a_in_vec   = 16'h0001;
        cyc();
        a_in_valid = 0;
        repeat (3) cyc();
        chk("after_clr_cnt1", a_toggle_cnt, 64'd1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_vec    = 16'($urandom);
            a_out_ready = ($urandom_range(0, 9) < 7);
            a_cnt_clear = ($urandom_range(0, 49) == 0);
            cyc();
        end
        a_in_valid  = 0;
        a_cnt_clear = 0;
        a_out_ready = 1;
        repeat (4) cyc();
        chk("rand_drained", 64'(q.size()), 64'd0);

        // Reset with two samples in flight
        a_in_valid = 1;
        a_in_vec   = 16'hFFFF;
        cyc();
        a_in_vec   = 16'h9999;
        cyc();
        a_in_valid = 0;
        rst = 1;
        #1;
        chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_cnt", a_toggle_cnt, 64'd0);
        chk("mid_rst_in_ready", 64'(a_in_ready), 64'd0);
        cyc();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 64'(a_out_valid), 64'd0);
            cyc();
        end
        a_in_valid = 1;
        a_in_vec   = 16'h5A3C;
        @(negedge clk);
        chk("post_rst_accept", 64'(a_in_ready), 64'd1);
        cyc();
        a_in_valid = 0;
        @(negedge clk);
        chk("post_rst_lat1", 64'(a_out_valid), 64'd0);
        cyc();
        @(negedge clk);
        chk("post_rst_lat2_v", 64'(a_out_valid), 64'd1);
        chk("post_rst_lat2_f", 64'(a_out_f), 64'(fref4(16'h5A3C)));
        cyc();

        // Saturation of a 3-bit counter with alternating results
        s_cnt_clear = 1;
        cyc();
        s_cnt_clear = 0;
        for (int i = 0; i < 6; i++) begin
            s_in_valid = 1;
            s_in_vec   = (i % 2 == 0) ? 4'h1 : 4'h0;
            cyc();
        end
        s_in_valid = 0;
        repeat (3) cyc();
        chk("sat_cnt6", 64'(s_toggle_cnt), 64'd6);
        chk("sat_flag0", 64'(s_cnt_sat), 64'd0);
        for (int i = 0; i < 4; i++) begin
            s_in_valid = 1;
            s_in_vec   = (i % 2 == 0) ? 4'h1 : 4'h0;
            cyc();
        end
        s_in_valid = 0;
        repeat (3) cyc();
        chk("sat_cnt7", 64'(s_toggle_cnt), 64'd7);
        chk("sat_flag1", 64'(s_cnt_sat), 64'd1);
        for (int i = 0; i < 2; i++) begin
            s_in_valid = 1;
            s_in_vec   = (i == 0) ? 4'h1 : 4'h0;
            cyc();
        end
        s_in_valid = 0;
        repeat (3) cyc();
        chk("sat_hold7", 64'(s_toggle_cnt), 64'd7);
        chk("sat_hold_flag", 64'(s_cnt_sat), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got %0d compares expected completion", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwr_subckt_eval_pipe.md
Name: pwr_subckt_eval_pipe

Overview:
- Parametrised, multi-channel, pipelined evaluator of the 4-input power-experiment sub-circuit function.
- Each channel carries a 4-bit input sample through an elastic valid/ready pipeline and produces a 1-bit result.
- A per-channel saturating output-toggle counter provides switching-activity data for power characterisation.
- Sits between the stimulus generator and the activity-collection logic in the power experiment harness.

Parameters:
- CHANNELS, 4: number of independent channels evaluated in parallel.
- LATENCY, 2: pipeline register stages, at least 1; accept-to-output delay in cycles with no backpressure.
- CNT_W, 16: width of each toggle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  pipeline can accept a sample this cycle.
- in_vec  in  4*CHANNELS  channel i occupies bits [4i+3:4i]. Bit 0 = a, bit 1 = b, bit 2 = c, bit 3 = d.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_f  out  CHANNELS  bit i is the result for channel i.
- cnt_clear  in  1  synchronous clear of all toggle counters and history.
- toggle_cnt  out  CNT_W*CHANNELS  channel i occupies bits [CNT_W*i +: CNT_W].
- cnt_sat  out  CHANNELS  bit i is high while counter i equals 2^CNT_W-1.

Behaviour:
- Function, per channel: x = a XOR c; f = (d OR x) AND (a OR (b AND x)).
  - f is evaluated combinationally from in_vec before the first register stage.
  - Only f is carried down the pipeline, so stage data width is CHANNELS bits.
- Pipeline: LATENCY stages, each holding a valid bit and CHANNELS data bits.
  - Last stage advances when out_valid AND out_ready.
  - Stage k loads from stage k-1 (or from the input for k=0) when it is empty or advancing in the same cycle.
  - in_ready = stage 0 empty or stage 0 advancing. The ready chain is combinational.
  - A sample is accepted on in_valid AND in_ready.
  - out_valid and out_f come from the last stage.
  - Throughput is 1 sample per cycle when out_ready is held high.
  - Data stays stable while out_valid=1 and out_ready=0.
  - No sample is dropped or duplicated.
  - A bubble on the input propagates as invalid. Downstream stages keep draining while the input is idle.
- Toggle counting, per channel: a history bit prev_i, reset to 0.
  - On each output transfer: if out_f[i] != prev_i, toggle_cnt[i] increments, saturating at 2^CNT_W-1 with no wrap.
  - prev_i <= out_f[i] on every transfer.
  - cnt_clear zeroes all counters and prev bits. It has priority over a same-cycle transfer, so that transfer is not counted but the result is still delivered.
  - cnt_sat is combinational from the counter value.
- Reset, asynchronous and effective immediately, including mid-operation:
  - All stage valid bits = 0; pipeline contents are discarded.
  - out_valid = 0, out_f = 0, toggle_cnt = 0, prev = 0, cnt_sat = 0.
  - in_ready = 1 while rst is low; in_ready = 0 while rst is high.
- Simultaneous accept and transfer with a full pipeline is legal and keeps occupancy constant.

Test Plan:
- Truth table, CHANNELS=1, LATENCY=2, out_ready=1. Drive all 16 abcd codes, one per cycle. out_f must match f two cycles later.
  - Examples: a=1,c=0 -> 1; a=0,b=0,c=1 -> 0; a=1,c=1,d=0 -> 0; a=1,c=1,d=1 -> 1.
- Backpressure, CHANNELS=4: send 6 samples with out_ready=0.
  - in_ready must drop after LATENCY samples are held.
  - Raise out_ready: all 6 results emerge in order, held stable while stalled, with no loss or duplication.
- Toggle count: one channel receives results 1,0,0,1,1 -> toggle_cnt=3. Then cnt_clear with a concurrent transfer of 0 -> count 0, prev 0.
- Saturation, CNT_W=3: alternate results for 10 transfers. Counter must stop at 7 with cnt_sat=1; further toggles keep it at 7.
- Reset mid-stream: assert rst with 2 samples in flight.
  - Immediately out_valid=0 and counters=0.
  - After release, a new sample appears LATENCY cycles after acceptance; no stale data emerges.
- Bubbles, LATENCY=3: in_valid pattern 1,0,1. Outputs are valid exactly at cycles 3 and 5 after the first accept.
